// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arb_pkg
// Description : Shared types and helpers for the SDRAM port arbiter.
//               - arb_state_t : arbiter FSM state encoding (2 bits)
//               - ARB_ID_W    : width of a port index for n requesters
//               - TO_CNT_W    : grant watchdog counter width, clamped 8..16
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    function automatic int ARB_ID_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int TO_CNT_W(input int limit);
        int w;
        w = $clog2(limit + 1);
        if (w < 8)  w = 8;
        if (w > 16) w = 16;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : sdram_rr_picker
// Description : Combinational round-robin picker. Searches req upward from
//               rr_ptr (wrapping) and reports the first requesting index.
// Ports       : req    [NUM_PORTS] in  - request vector
//               rr_ptr [ID_W]      in  - highest-priority index
//               valid              out - at least one request present
//               idx    [ID_W]      out - winning index (0 when !valid)
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_rr_picker
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ID_W      = ARB_ID_W(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [ID_W-1:0]      rr_ptr,
    output logic                 valid,
    output logic [ID_W-1:0]      idx
);

    int              sum;
    logic [ID_W-1:0] cand;

    // Scan from the farthest offset down to offset 0 so that the candidate
    // closest to rr_ptr is the last one assigned and therefore wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        sum   = 0;
        cand  = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            sum = int'(rr_ptr) + k;
            if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
            cand = sum[ID_W-1:0];
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_port_arbiter
// Description : Round-robin arbiter sharing one SDRAM controller host port
//               among NUM_PORTS requesters. Latches one request, holds it on
//               m_rreq/m_wreq until granted, then pulses p_ack for one cycle.
// Ports       : clk, rst (sync, active-high)
//               p_req/p_we/p_addr/p_wdata  in  - packed per-port requests
//               p_ack/p_err                out - one-hot completion / abort
//               p_rdata                    out - registered read data
//               grant_id                   out - current owner
//               m_*                            - controller host interface
// Options     : SDRAM_ARB_TIMEOUT_EN - grant watchdog of TIMEOUT_CYCLES
//               ISSUE cycles; aborts with p_ack+p_err. Off: p_err tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int ADDR_WIDTH     = 24,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             p_req,
    input  logic [NUM_PORTS-1:0]             p_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  p_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  p_wdata,
    output logic [NUM_PORTS-1:0]             p_ack,
    output logic [NUM_PORTS-1:0]             p_err,
    output logic [DATA_WIDTH-1:0]            p_rdata,
    output logic [$clog2(NUM_PORTS)-1:0]     grant_id,
    output logic                             m_rreq,
    output logic                             m_wreq,
    output logic [ADDR_WIDTH-1:0]            m_raddr,
    output logic [ADDR_WIDTH-1:0]            m_waddr,
    output logic [DATA_WIDTH-1:0]            m_wdata,
    input  logic                             m_rgnt,
    input  logic                             m_wgnt,
    input  logic [DATA_WIDTH-1:0]            m_rdata
);

    localparam int ID_W = ARB_ID_W(NUM_PORTS);

    if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
    begin : g_param_check
        $error("sdram_port_arbiter: parameter out of range");
    end

    arb_state_t             state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]        grant_id_q, grant_id_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [NUM_PORTS-1:0]   ack_q, ack_d;
    logic                   rreq_q, rreq_d;
    logic                   wreq_q, wreq_d;

    logic                   w_pick_valid;
    logic [ID_W-1:0]        w_pick_id;
    logic                   w_grant_hit;
    logic                   w_timeout;
    logic [ID_W-1:0]        w_ptr_next;

    sdram_rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .ID_W      (ID_W)
    ) u_picker (
        .req    (p_req),
        .rr_ptr (rr_ptr_q),
        .valid  (w_pick_valid),
        .idx    (w_pick_id)
    );

    // Only the grant matching the latched direction completes the request.
    assign w_grant_hit = (state_q == ISSUE) && (we_q ? m_wgnt : m_rgnt);
    assign w_ptr_next  = (grant_id_q == ID_W'(NUM_PORTS - 1)) ? '0 : grant_id_q + 1'b1;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int              CNT_W    = TO_CNT_W(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]     to_cnt_q, to_cnt_d;
    logic [NUM_PORTS-1:0] err_q, err_d;

    // Counter holds the number of ISSUE cycles already spent; the abort
    // fires in the TIMEOUT_CYCLES-th ISSUE cycle. A real grant wins a tie.
    assign w_timeout = (state_q == ISSUE) && !w_grant_hit && (to_cnt_q == CNT_LAST);

    always_comb begin
        to_cnt_d = to_cnt_q;
        err_d    = '0;
        if (state_q == IDLE)       to_cnt_d = '0;
        else if (state_q == ISSUE) to_cnt_d = to_cnt_q + 1'b1;
        if (w_timeout)             err_d[grant_id_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            err_q    <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign p_err = err_q;
`else
    assign w_timeout = 1'b0;
    assign p_err     = '0;
`endif

    // State register and all datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ack_q      <= '0;
            rreq_q     <= 1'b0;
            wreq_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            rreq_q     <= rreq_d;
            wreq_q     <= wreq_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_pick_valid) state_d = ISSUE;
            ISSUE:   if (w_grant_hit || w_timeout) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ack_d      = '0;
        rreq_d     = rreq_q;
        wreq_d     = wreq_q;
        case (state_q)
            IDLE: begin
                if (w_pick_valid) begin
                    grant_id_d = w_pick_id;
                    we_d       = p_we[w_pick_id];
                    addr_d     = p_addr[int'(w_pick_id)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d    = p_wdata[int'(w_pick_id)*DATA_WIDTH +: DATA_WIDTH];
                    rreq_d     = ~p_we[w_pick_id];
                    wreq_d     = p_we[w_pick_id];
                end
            end
            ISSUE: begin
                if (w_grant_hit || w_timeout) begin
                    rreq_d            = 1'b0;
                    wreq_d            = 1'b0;
                    ack_d[grant_id_q] = 1'b1;
                    rr_ptr_d          = w_ptr_next;
                    if (w_grant_hit && !we_q) rdata_d = m_rdata;
                end
            end
            default: begin
                rreq_d = 1'b0;
                wreq_d = 1'b0;
            end
        endcase
    end

    assign p_ack    = ack_q;
    assign p_rdata  = rdata_q;
    assign grant_id = grant_id_q;
    assign m_rreq   = rreq_q;
    assign m_wreq   = wreq_q;
    assign m_raddr  = addr_q;
    assign m_waddr  = addr_q;
    assign m_wdata  = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_port_arbiter
// Description : Self-checking bench for sdram_port_arbiter. A negedge-driven
//               controller model grants after a configurable delay (or never)
//               and may toggle the non-matching grant as noise. Expected
//               service order, latency, data and acks come from a
//               transaction-level round-robin model kept in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 24;
    localparam int DW = 16;
    localparam int TO = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      p_req = '0, p_we = '0;
    logic [N*AW-1:0]   p_addr = '0;
    logic [N*DW-1:0]   p_wdata = '0;
    logic [N-1:0]      p_ack, p_err;
    logic [DW-1:0]     p_rdata;
    logic [1:0]        grant_id;
    logic              m_rreq, m_wreq;
    logic [AW-1:0]     m_raddr, m_waddr;
    logic [DW-1:0]     m_wdata;
    logic              m_rgnt = 1'b0, m_wgnt = 1'b0;
    logic [DW-1:0]     m_rdata = '0;

    sdram_port_arbiter #(
        .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .p_req(p_req), .p_we(p_we), .p_addr(p_addr),
        .p_wdata(p_wdata), .p_ack(p_ack), .p_err(p_err), .p_rdata(p_rdata),
        .grant_id(grant_id), .m_rreq(m_rreq), .m_wreq(m_wreq),
        .m_raddr(m_raddr), .m_waddr(m_waddr), .m_wdata(m_wdata),
        .m_rgnt(m_rgnt), .m_wgnt(m_wgnt), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          model_ptr   = 0;
    logic [DW-1:0] model_rdata = '0;
    logic          tb_we   [N];
    logic [AW-1:0] tb_addr [N];
    logic [DW-1:0] tb_wdata[N];

    // Controller model state
    int            ctl_delay = 0;
    bit            ctl_hang  = 0;
    bit            ctl_noise = 0;
    int            ctl_cnt   = 0;
    logic [AW-1:0] cap_addr  = '0;
    logic          cap_we    = 1'b0;
    logic [DW-1:0] cap_wdata = '0;
    int            excl_viol = 0;

    function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
        if (a == 24'h012345) return 16'hBEEF;
        return a[15:0] ^ {a[23:16], a[7:0]} ^ 16'h3C5A;
    endfunction

    // Controller: grant once the request has been visible for ctl_delay
    // earlier cycles; delay 0 grants in the cycle the request rises.
    always @(negedge clk) begin
        if (m_rreq && m_wreq) excl_viol++;
        if (rst || !(m_rreq || m_wreq)) begin
            ctl_cnt = 0;
            m_rgnt  = 1'b0;
            m_wgnt  = 1'b0;
        end else begin
            if (!ctl_hang && ctl_cnt == ctl_delay) begin
                m_rgnt    = m_rreq;
                m_wgnt    = m_wreq;
                m_rdata   = m_rreq ? rd_fn(m_raddr) : DW'($urandom);
                cap_addr  = m_rreq ? m_raddr : m_waddr;
                cap_we    = m_wreq;
                cap_wdata = m_wdata;
            end else begin
                m_rgnt  = ctl_noise && m_wreq && ($urandom_range(0, 1) == 1);
                m_wgnt  = ctl_noise && m_rreq && ($urandom_range(0, 1) == 1);
                m_rdata = DW'($urandom);
            end
            ctl_cnt++;
        end
    end

    task automatic drive_port(input int i);
        p_we[i]             = tb_we[i];
        p_addr[i*AW +: AW]  = tb_addr[i];
        p_wdata[i*DW +: DW] = tb_wdata[i];
        p_req[i]            = 1'b1;
    endtask

    task automatic randomize_ports();
        for (int i = 0; i < N; i++) begin
            tb_we[i]    = ($urandom_range(0, 1) == 1);
            tb_addr[i]  = AW'($urandom);
            tb_wdata[i] = DW'($urandom);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        p_req    = '0;
        ctl_hang = 0;
        repeat (2) @(negedge clk);
        rst         = 1'b0;
        model_ptr   = 0;
        model_rdata = '0;
    endtask

    // Serve one burst of simultaneous requests; the model predicts the order
    // (rotation from model_ptr), every ack time, and the data on both sides.
    task automatic run_round(input logic [N-1:0] mask, input int delay,
                             input bit noise, input string name);
        int order[$];
        int served, cyc, last, w, exp_cyc;
        logic [N-1:0] exp_oh;
        for (int k = 0; k < N; k++) begin
            if (mask[(model_ptr + k) % N]) order.push_back((model_ptr + k) % N);
        end
        ctl_delay = delay;
        ctl_noise = noise;
        ctl_hang  = 0;
        @(negedge clk);
        for (int i = 0; i < N; i++) if (mask[i]) drive_port(i);
        served = 0; cyc = 0; last = 0;
        while (served < order.size() && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (p_ack != '0) begin
                w       = order[served];
                exp_oh  = N'(1) << w;
                exp_cyc = (served == 0) ? delay + 2 : last + delay + 3;
                total++; if (p_ack !== exp_oh) begin bad++; $display("FAIL %s ack: got=%b exp=%b", name, p_ack, exp_oh); end
                total++; if (p_err !== '0) begin bad++; $display("FAIL %s err: got=%b exp=0", name, p_err); end
                total++; if (grant_id !== 2'(w)) begin bad++; $display("FAIL %s grant_id: got=%0d exp=%0d", name, grant_id, w); end
                total++; if (cyc != exp_cyc) begin bad++; $display("FAIL %s ack_time: got=%0d exp=%0d", name, cyc, exp_cyc); end
                total++; if (cap_addr !== tb_addr[w] || cap_we !== tb_we[w]) begin
                    bad++; $display("FAIL %s m_addr/we: got=%h/%b exp=%h/%b", name, cap_addr, cap_we, tb_addr[w], tb_we[w]);
                end
                if (tb_we[w]) begin
                    total++; if (cap_wdata !== tb_wdata[w]) begin bad++; $display("FAIL %s m_wdata: got=%h exp=%h", name, cap_wdata, tb_wdata[w]); end
                end else begin
                    model_rdata = rd_fn(tb_addr[w]);
                end
                total++; if (p_rdata !== model_rdata) begin bad++; $display("FAIL %s p_rdata: got=%h exp=%h", name, p_rdata, model_rdata); end
                p_req[w]  = 1'b0;
                last      = cyc;
                served++;
                model_ptr = (w + 1) % N;
            end
        end
        if (served < order.size()) begin
            total++; bad++;
            $display("FAIL %s served: got=%0d exp=%0d (cycle budget expired)", name, served, order.size());
        end
        p_req = '0;
        @(negedge clk);
        total++; if (p_ack !== '0) begin bad++; $display("FAIL %s idle_ack: got=%b exp=0", name, p_ack); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (p_ack !== '0 || p_err !== '0) begin bad++; $display("FAIL reset ack/err: got=%b/%b exp=0/0", p_ack, p_err); end
        total++; if (m_rreq !== 1'b0 || m_wreq !== 1'b0) begin bad++; $display("FAIL reset req: got=%b%b exp=00", m_rreq, m_wreq); end
        total++; if (p_rdata !== '0 || grant_id !== '0) begin bad++; $display("FAIL reset rdata/gid: got=%h/%0d exp=0/0", p_rdata, grant_id); end
        total++; if (m_raddr !== '0 || m_waddr !== '0 || m_wdata !== '0) begin bad++; $display("FAIL reset m_bus: got=%h/%h/%h exp=0", m_raddr, m_waddr, m_wdata); end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        randomize_ports();
        tb_we[2]   = 1'b0;
        tb_addr[2] = 24'h012345;
        run_round(4'b0100, 6, 0, "single_read");
        total++; if (p_rdata !== 16'hBEEF) begin bad++; $display("FAIL single_read beef: got=%h exp=beef", p_rdata); end
    endtask

    task automatic test_all_ports();
        do_reset();
        randomize_ports();
        run_round(4'b1111, 2, 0, "all_ports");
        run_round(4'b0001, 1, 0, "port0_again");
    endtask

    task automatic test_mixed();
        int v0;
        randomize_ports();
        tb_we[1] = 1'b1; tb_addr[1] = 24'h000010; tb_wdata[1] = 16'h00A5;
        tb_we[3] = 1'b0;
        v0 = excl_viol;
        run_round(4'b1010, 3, 1, "mixed");
        total++; if (excl_viol != v0) begin bad++; $display("FAIL mixed exclusive: got=%0d exp=%0d", excl_viol, v0); end
    endtask

    task automatic test_back_to_back();
        int acks, cyc;
        randomize_ports();
        tb_we[0] = 1'b0;
        ctl_delay = 0; ctl_noise = 0; ctl_hang = 0;
        @(negedge clk);
        drive_port(0);
        acks = 0; cyc = 0;
        while (acks < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (p_ack != '0) begin
                total++; if (p_ack !== 4'b0001 || cyc != 2 + 3 * acks) begin
                    bad++; $display("FAIL back_to_back ack%0d: got=%b@%0d exp=0001@%0d", acks, p_ack, cyc, 2 + 3 * acks);
                end
                acks++;
                if (acks == 4) p_req[0] = 1'b0;
            end
        end
        total++; if (acks != 4) begin bad++; $display("FAIL back_to_back count: got=%0d exp=4", acks); end
        model_ptr   = 1;
        model_rdata = rd_fn(tb_addr[0]);
        p_req = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        randomize_ports();
        run_round(4'b0100, 1, 0, "pre_reset");   // leaves rotation at port 3
        ctl_hang = 1;
        @(negedge clk);
        drive_port(0);
        repeat (4) @(negedge clk);
        total++; if ((m_rreq | m_wreq) !== 1'b1) begin bad++; $display("FAIL reset_mid busy: got=%b exp=1", m_rreq | m_wreq); end
        rst = 1'b1;
        @(negedge clk);
        total++; if ({p_ack, p_err, m_rreq, m_wreq, grant_id} !== '0 || p_rdata !== '0 ||
                     m_raddr !== '0 || m_waddr !== '0 || m_wdata !== '0) begin
            bad++; $display("FAIL reset_mid outputs: got ack=%b err=%b req=%b%b gid=%0d rd=%h ra=%h wa=%h wd=%h exp=0",
                            p_ack, p_err, m_rreq, m_wreq, grant_id, p_rdata, m_raddr, m_waddr, m_wdata);
        end
        rst = 1'b0; p_req = '0; ctl_hang = 0;
        model_ptr = 0; model_rdata = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++; if (p_ack !== '0) begin bad++; $display("FAIL reset_mid no_ack: got=%b exp=0", p_ack); end
        end
        randomize_ports();
        run_round(4'b1010, 1, 0, "after_reset");
    endtask

`ifdef SDRAM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int first, second, cyc;
        bit got;
        first = -1; second = -1;
        for (int k = 0; k < N; k++) begin
            if (((model_ptr + k) % N == 1) || ((model_ptr + k) % N == 2)) begin
                if (first < 0) first = (model_ptr + k) % N; else second = (model_ptr + k) % N;
            end
        end
        randomize_ports();
        tb_we[second] = 1'b0;
        ctl_hang = 1; ctl_delay = 1; ctl_noise = 1;
        @(negedge clk);
        drive_port(1); drive_port(2);
        cyc = 0; got = 0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (p_ack != '0) begin
                got = 1;
                total++; if (p_ack !== N'(1) << first || p_err !== N'(1) << first || cyc != TO + 1) begin
                    bad++; $display("FAIL timeout abort: got ack=%b err=%b@%0d exp=%b@%0d", p_ack, p_err, cyc, N'(1) << first, TO + 1);
                end
                total++; if (p_rdata !== model_rdata) begin bad++; $display("FAIL timeout rdata: got=%h exp=%h", p_rdata, model_rdata); end
                p_req[first] = 1'b0;
                ctl_hang = 0;
            end
        end
        if (!got) begin total++; bad++; $display("FAIL timeout abort: got=none exp=ack"); end
        got = 0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (p_ack != '0) begin
                got = 1;
                model_rdata = rd_fn(tb_addr[second]);
                total++; if (p_ack !== N'(1) << second || p_err !== '0 || cyc != TO + 5 || p_rdata !== model_rdata) begin
                    bad++; $display("FAIL timeout next: got ack=%b err=%b@%0d rd=%h exp=%b@%0d rd=%h",
                                    p_ack, p_err, cyc, p_rdata, N'(1) << second, TO + 5, model_rdata);
                end
            end
        end
        if (!got) begin total++; bad++; $display("FAIL timeout next: got=none exp=ack"); end
        p_req = '0; ctl_noise = 0;
        model_ptr = (second + 1) % N;
        @(negedge clk);
    endtask
`else
    task automatic test_timeout();
        int acks, busy;
        randomize_ports();
        ctl_hang = 1;
        @(negedge clk);
        drive_port(1);
        acks = 0; busy = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (p_ack != '0 || p_err != '0) acks++;
            if (m_rreq || m_wreq) busy++;
        end
        total++; if (acks != 0) begin bad++; $display("FAIL no_timeout acks: got=%0d exp=0", acks); end
        total++; if (busy != 60) begin bad++; $display("FAIL no_timeout busy: got=%0d exp=60", busy); end
        do_reset();
    endtask
`endif

    task automatic test_random();
        for (int r = 0; r < 20; r++) begin
            randomize_ports();
            run_round(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 5),
                      ($urandom_range(0, 1) == 1), "random");
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_all_ports();
        test_mixed();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single host read/write interface of the SDRAM controller among `NUM_PORTS` requesters (video fetch, CPU, DMA, …) with round-robin fairness. It latches one port's request, presents it on the controller's `rreq`/`wreq` side, and holds it stable until the controller grants it. It then returns read data and a one-cycle acknowledge to the winning port.

## Interface
- `NUM_PORTS`, 4: number of requesters, 2..8.
- `ADDR_WIDTH`, 24: host address width, equal to bank+row+col of the controller.
- `DATA_WIDTH`, 16: data width.
- `TIMEOUT_CYCLES`, 255: grant watchdog limit, used only with `SDRAM_ARB_TIMEOUT_EN`.
- `clk`  in  1  single clock, shared with the controller.
- `rst`  in  1  reset, synchronous, active-high.
- `p_req`  in  NUM_PORTS  per-port request, level.
- `p_we`  in  NUM_PORTS  per-port direction, 1 = write.
- `p_addr`  in  NUM_PORTS*ADDR_WIDTH  packed addresses, port i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `p_wdata`  in  NUM_PORTS*DATA_WIDTH  packed write data.
- `p_ack`  out  NUM_PORTS  one-cycle completion pulse, one-hot.
- `p_err`  out  NUM_PORTS  timeout abort pulse, coincident with `p_ack`; tied 0 without the macro.
- `p_rdata`  out  DATA_WIDTH  read data, broadcast, valid when `p_ack[i] & ~p_we[i]`.
- `grant_id`  out  $clog2(NUM_PORTS)  port currently owning the controller.
- `m_rreq`, `m_wreq`  out  1  to the controller's `rreq`/`wreq`.
- `m_raddr`, `m_waddr`  out  ADDR_WIDTH  to the controller's `raddr`/`waddr`.
- `m_wdata`  out  DATA_WIDTH  to the controller's `wdata`.
- `m_rgnt`, `m_wgnt`  in  1  from the controller.
- `m_rdata`  in  DATA_WIDTH  from the controller's `rdata`.

## Operation
- **States:** IDLE, ISSUE, RELEASE.
- **IDLE**
  - If any `p_req` is set, pick the first requesting port searching upward from `rr_ptr`, wrapping.
  - Latch the port id, `p_we`, address and wdata into internal registers.
  - Go to ISSUE.
- **ISSUE**
  - Drive `m_rreq` (we=0) or `m_wreq` (we=1) from the latched registers; both address outputs carry the latched address.
  - Only one of `m_rreq`/`m_wreq` is ever high.
  - On the matching grant (`m_rgnt` for reads, `m_wgnt` for writes): capture `m_rdata` for reads, set `rr_ptr` = winner+1 mod NUM_PORTS, go to RELEASE.
  - The non-matching grant is ignored.
- **RELEASE**
  - `m_rreq`/`m_wreq` are low.
  - `p_ack[winner]` is high for exactly this cycle.
  - Go to IDLE. The deasserted cycle lets the controller return to its idle status and re-check its caches.
- **Port rule:** hold `p_req`, `p_we`, `p_addr`, `p_wdata` until the `p_ack` pulse. If `p_req` is still high in the cycle after ack, that is a new request.
- **Request dropped before ack:** protocol violation. The arbiter still completes using the latched values and still acks.
- **Simultaneous requests:** strict rotation from `rr_ptr`. A port that stays requesting waits at most NUM_PORTS−1 transactions.
- **Repeat read/write of the same address:** the controller may grant in the first ISSUE cycle. This is legal and gives minimum latency.
- **Reset:**
  - All outputs 0.
  - `grant_id`=0, `rr_ptr`=0, state IDLE.
  - Latched registers 0.
  - An in-flight transaction is abandoned with no ack.

## Timing
- Request seen at edge T (IDLE). `m_*req` is high from T+1. Grant at edge G ≥ T+1. `p_ack` is high in cycle G+1. The next pick happens at G+2.
- Minimum turnaround is 3 cycles per transaction. Throughput is one transaction per (controller latency + 2) cycles.
- `p_rdata` is registered and holds its value until the next read completes.
- All outputs are registered. There is no combinational path from the `p_*` inputs to the `m_*` outputs.

## Configuration
- **`SDRAM_ARB_TIMEOUT_EN` defined:**
  - An 8..16-bit counter runs in ISSUE.
  - When it reaches `TIMEOUT_CYCLES` without a grant: drop the request, pulse `p_ack` and `p_err` for the winner, leave `p_rdata` unchanged, advance `rr_ptr`, go to RELEASE.
  - The counter clears on entry to ISSUE.
- **Undefined:** no counter; ISSUE waits indefinitely; `p_err` is constant 0.

## Structure
- Package `sdram_arb_pkg` holds:
  - the `arb_state_t` enum {IDLE, ISSUE, RELEASE};
  - the `ARB_ID_W` function/localparam for the id width.
- Sub-module `sdram_rr_picker`: combinational round-robin picker. Inputs are the request vector and `rr_ptr`; outputs are a `valid` flag and the winner index. Instantiated once.

## Test plan
- **Single read:** port 2 reads addr 0x012345; controller model grants 6 cycles after `m_rreq` with 0xBEEF → `m_raddr`=0x012345, `p_ack`=4'b0100 one cycle after grant, `p_rdata`=0xBEEF.
- **All ports at once:** all four ports request with `rr_ptr`=0 → service order 0,1,2,3. Then port 0 alone re-requests and is served next.
- **Mixed direction:** port 1 writes 0x00A5 to 0x000010 while port 3 reads → `m_wreq` and `m_rreq` are never high together, and the write data reaches `m_wdata` unchanged.
- **Reset mid-operation:** assert `rst` while in ISSUE → next cycle all outputs are 0 and no `p_ack` is issued; a fresh request afterwards is served normally starting from port 0 priority.
- **Timeout (macro on, `TIMEOUT_CYCLES`=20):** controller never grants → after 20 ISSUE cycles `p_ack` and `p_err` pulse for the winner, and the next port is then served. With the macro off, the arbiter stays in ISSUE.
- **Immediate grant:** controller grants in the same cycle `m_rreq` rises → ack arrives 2 cycles after the request was latched, and back-to-back requests from one port are spaced 3 cycles apart.
